// File: rtl/load_store_unit.sv
// Load/store unit: runs one data-memory transaction per load/store over a
// req/ack handshake. It handles byte-lane steering, sign/zero extension,
// misalignment detection and a request timeout, and emits a one-cycle response.
module load_store_unit #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W          = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [5:0]  alucode,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_misalign,
    output logic        resp_timeout,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);
    // Memory alucodes; these must stay in sync with define.vh.
    localparam logic [5:0] ALU_LB  = 6'd20;
    localparam logic [5:0] ALU_LH  = 6'd21;
    localparam logic [5:0] ALU_LW  = 6'd22;
    localparam logic [5:0] ALU_LBU = 6'd23;
    localparam logic [5:0] ALU_LHU = 6'd24;
    localparam logic [5:0] ALU_SB  = 6'd25;
    localparam logic [5:0] ALU_SH  = 6'd26;
    localparam logic [5:0] ALU_SW  = 6'd27;

    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

    state_t      state, next_state;
    logic [5:0]  op_q;
    logic [31:0] addr_q, sdata_q, rdata_q, load_ext;
    logic [CNT_W-1:0] cnt;
    logic        mis_q, to_q;
    logic        in_ls, in_mis, accept, timeout_hit, is_store;
    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    assign accept   = in_valid && in_ready;
    assign is_store = (op_q == ALU_SB) || (op_q == ALU_SH) || (op_q == ALU_SW);
    // The ack takes priority, so expiry only matters when no ack arrives.
    assign timeout_hit = (TIMEOUT_CYCLES != 0) &&
                         (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    // Classify the incoming op: is it a memory op, and is it misaligned?
    always_comb begin
        in_ls  = 1'b0;
        in_mis = 1'b0;
        case (alucode)
            ALU_LB, ALU_LBU, ALU_SB: in_ls = 1'b1;
            ALU_LH, ALU_LHU, ALU_SH: begin in_ls = 1'b1; in_mis = addr[0]; end
            ALU_LW, ALU_SW:          begin in_ls = 1'b1; in_mis = |addr[1:0]; end
            default: ;
        endcase
    end

    // Extract and extend load data from the returned word.
    always_comb begin
        lane_b   = mem_rdata[8*addr_q[1:0] +: 8];
        lane_h   = mem_rdata[16*addr_q[1] +: 16];
        load_ext = 32'd0;
        case (op_q)
            ALU_LB:  load_ext = {{24{lane_b[7]}}, lane_b};
            ALU_LBU: load_ext = {24'd0, lane_b};
            ALU_LH:  load_ext = {{16{lane_h[15]}}, lane_h};
            ALU_LHU: load_ext = {16'd0, lane_h};
            ALU_LW:  load_ext = mem_rdata;
            default: load_ext = 32'd0;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    // Next-state logic.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (accept) next_state = (in_ls && !in_mis) ? REQ : RESP;
            REQ:  if (mem_ack || timeout_hit) next_state = RESP;
            RESP: next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Op latch, timeout counter and response capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q    <= 6'd0;
            addr_q  <= 32'd0;
            sdata_q <= 32'd0;
            rdata_q <= 32'd0;
            cnt     <= '0;
            mis_q   <= 1'b0;
            to_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (accept) begin
                        op_q    <= alucode;
                        addr_q  <= addr;
                        sdata_q <= store_data;
                        rdata_q <= 32'd0;
                        mis_q   <= in_mis;
                        to_q    <= 1'b0;
                    end
                end
                REQ: begin
                    cnt <= cnt + CNT_W'(1);
                    if (mem_ack)          rdata_q <= load_ext;
                    else if (timeout_hit) to_q    <= 1'b1;
                end
                default: cnt <= '0;
            endcase
        end
    end

    // Outputs decode from state so an async reset drops them at once.
    always_comb begin
        in_ready      = (state == IDLE);
        mem_req       = (state == REQ);
        resp_valid    = (state == RESP);
        mem_we        = mem_req && is_store;
        mem_addr      = mem_req ? {addr_q[31:2], 2'b00} : 32'd0;
        mem_wstrb     = 4'd0;
        mem_wdata     = 32'd0;
        resp_rdata    = resp_valid ? rdata_q : 32'd0;
        resp_misalign = resp_valid && mis_q;
        resp_timeout  = resp_valid && to_q;
        if (mem_we) begin
            case (op_q)
                ALU_SB: begin
                    mem_wstrb = 4'b0001 << addr_q[1:0];
                    mem_wdata = {4{sdata_q[7:0]}};
                end
                ALU_SH: begin
                    mem_wstrb = addr_q[1] ? 4'b1100 : 4'b0011;
                    mem_wdata = {2{sdata_q[15:0]}};
                end
                default: begin
                    mem_wstrb = 4'b1111;
                    mem_wdata = sdata_q;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: a random op stream with random ack latencies is
// checked every cycle against a transaction-level model, and directed ops pin
// known values.
module tb_load_store_unit;
    localparam int TO = 16;
    localparam logic [5:0] LB = 6'd20, LH = 6'd21, LW = 6'd22, LBU = 6'd23,
                           LHU = 6'd24, SB = 6'd25, SH = 6'd26, SW = 6'd27;

    logic        clk = 0, rst = 1;
    logic        in_valid = 0, in_ready;
    logic [5:0]  alucode = 0;
    logic [31:0] addr = 0, store_data = 0;
    logic        resp_valid, resp_misalign, resp_timeout;
    logic [31:0] resp_rdata;
    logic        mem_req, mem_we, mem_ack = 0;
    logic [31:0] mem_addr, mem_wdata, mem_rdata = 0;
    logic [3:0]  mem_wstrb;

    load_store_unit #(.TIMEOUT_CYCLES(TO), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .alucode(alucode), .addr(addr), .store_data(store_data),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_misalign(resp_misalign), .resp_timeout(resp_timeout),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata));

    always #5 clk = ~clk;

    int total = 0, bad = 0;
    int req_cycles = 0, resp_count = 0;
    bit chk_en = 0;
    logic        exp_ir, exp_rv, exp_mis, exp_to, exp_req, exp_we;
    logic [31:0] exp_rdata, exp_maddr, exp_wdata;
    logic [3:0]  exp_strb;
    logic [31:0] last_rdata, last_maddr, last_wdata;
    logic [3:0]  last_strb;
    logic        last_we, last_mis, last_to;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_idle();
        exp_ir = 1; exp_rv = 0; exp_req = 0; exp_we = 0;
        exp_rdata = 0; exp_mis = 0; exp_to = 0;
        exp_maddr = 0; exp_strb = 0; exp_wdata = 0;
    endtask

    // Per-cycle compare against the model's expectation for this cycle.
    always @(negedge clk) begin
        if (chk_en) begin
            check("in_ready", in_ready, exp_ir);
            check("resp_valid", resp_valid, exp_rv);
            check("mem_req", mem_req, exp_req);
            check("mem_we", mem_we, exp_we);
            if (exp_req) begin
                check("mem_addr", mem_addr, exp_maddr);
                check("mem_wstrb", mem_wstrb, exp_strb);
                if (exp_we) check("mem_wdata", mem_wdata, exp_wdata);
            end
            if (exp_rv) begin
                check("resp_rdata", resp_rdata, exp_rdata);
                check("resp_misalign", resp_misalign, exp_mis);
                check("resp_timeout", resp_timeout, exp_to);
            end
            if (mem_req) begin
                req_cycles++;
                last_maddr = mem_addr; last_strb = mem_wstrb;
                last_wdata = mem_wdata; last_we = mem_we;
            end
            if (resp_valid) begin
                resp_count++;
                last_rdata = resp_rdata; last_mis = resp_misalign; last_to = resp_timeout;
            end
        end
    end

    // Issue one op and set expectations from the transaction-level rules:
    // lat = index of the REQ cycle that gets the ack (>= TO means no ack).
    task automatic run_op(input logic [5:0] code, input logic [31:0] a,
                          input logic [31:0] sd, input int lat, input logic [31:0] rd);
        bit ld, st, mis, to;
        int n, off;
        logic [31:0] ext, wd, b;
        logic [3:0] strb;
        ld  = code inside {LB, LH, LW, LBU, LHU};
        st  = code inside {SB, SH, SW};
        n   = (code inside {LH, LHU, SH}) ? 2 : (code inside {LW, SW}) ? 4 : 1;
        mis = (ld || st) && (a % n != 0);
        off = a % 4;
        ext = 0; wd = 0; strb = 0;
        case (code)
            LB, LBU: begin
                b = (rd >> (8 * off)) % 256;
                ext = (code == LB && b >= 128) ? b + 32'hFFFFFF00 : b;
            end
            LH, LHU: begin
                b = (rd >> (8 * off)) % 65536;
                ext = (code == LH && b >= 32768) ? b + 32'hFFFF0000 : b;
            end
            LW: ext = rd;
            SB: begin strb = 4'(1 << off); wd = (sd % 256) * 32'h01010101; end
            SH: begin strb = 4'(3 << off); wd = (sd % 65536) * 32'h00010001; end
            SW: begin strb = 4'hF; wd = sd; end
            default: ;
        endcase
        in_valid = 1; alucode = code; addr = a; store_data = sd;
        mem_ack = 1'($urandom % 2); mem_rdata = $urandom;
        @(posedge clk); #1;
        in_valid = 0; alucode = 6'($urandom); addr = $urandom; store_data = $urandom;
        to = 0;
        if ((ld || st) && !mis) begin
            for (int i = 0; i < 4 * TO; i++) begin
                exp_ir = 0; exp_req = 1; exp_we = st; exp_maddr = a - off;
                exp_strb = strb; exp_wdata = wd;
                mem_ack = (i == lat); mem_rdata = (i == lat) ? rd : $urandom;
                @(posedge clk); #1;
                if (i == lat) break;
                if (i == TO - 1) begin to = 1; break; end
            end
        end
        set_idle();
        exp_ir = 0; exp_rv = 1; exp_mis = mis; exp_to = to;
        exp_rdata = (ld && !mis && !to) ? ext : 0;
        mem_ack = 1'($urandom % 2); mem_rdata = $urandom;
        @(posedge clk); #1;
        set_idle();
        mem_ack = 0;
    endtask

    initial begin
        int rc, rq;
        logic [5:0] codes[9];
        codes = '{LB, LH, LW, LBU, LHU, SB, SH, SW, 6'd3};
        set_idle();
        #2;
        check("rst_in_ready", in_ready, 1);
        check("rst_outputs", {resp_valid, resp_misalign, resp_timeout, mem_req, mem_we, mem_wstrb}, 0);
        check("rst_data", resp_rdata | mem_addr | mem_wdata, 0);
        @(posedge clk); #1; rst = 0; chk_en = 1;

        // Directed pins.
        run_op(LW, 32'h100, 0, 0, 32'hDEADBEEF);
        check("lw_rdata", last_rdata, 32'hDEADBEEF);
        check("lw_addr", last_maddr, 32'h100);
        check("lw_strb", {last_we, last_strb}, 0);
        run_op(LB, 32'h203, 0, 2, 32'h80FF7F01);
        check("lb_rdata", last_rdata, 32'hFFFFFF80);
        check("lb_addr", last_maddr, 32'h200);
        run_op(LBU, 32'h203, 0, 1, 32'h80FF7F01);
        check("lbu_rdata", last_rdata, 32'h00000080);
        run_op(SH, 32'h12, 32'h0000ABCD, 0, 32'h12345678);
        check("sh_we_strb", {last_we, last_strb}, 5'b11100);
        check("sh_wdata", last_wdata, 32'hABCDABCD);
        check("sh_rdata", last_rdata, 0);
        rq = req_cycles; rc = resp_count;
        run_op(SW, 32'h6, 32'h55, 0, 0);
        check("sw_mis_noreq", req_cycles - rq, 0);
        check("sw_mis_flag", {last_mis, last_to}, 2'b10);
        check("sw_mis_resp", resp_count - rc, 1);
        rq = req_cycles;
        run_op(LW, 32'h40, 0, 99, 32'h1);
        check("to_req_cycles", req_cycles - rq, 16);
        check("to_flags", {last_mis, last_to}, 2'b01);
        check("to_rdata", last_rdata, 0);
        run_op(LHU, 32'h2, 0, TO - 1, 32'hBEEF1234);
        check("ack_at_expiry", {last_to, last_rdata}, {1'b0, 32'h0000BEEF});

        // Reset in REQ for a pending SB.
        in_valid = 1; alucode = SB; addr = 32'h301; store_data = 32'h77;
        @(posedge clk); #1;
        in_valid = 0;
        exp_ir = 0; exp_req = 1; exp_we = 1; exp_maddr = 32'h300;
        exp_strb = 4'b0010; exp_wdata = 32'h77777777;
        @(negedge clk); #2;
        chk_en = 0; rst = 1; #1;
        check("rst_async_req", mem_req, 0);
        check("rst_async_ready", in_ready, 1);
        rc = resp_count;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            check("rst_no_resp", {resp_valid, mem_req}, 0);
        end
        rst = 0; set_idle(); chk_en = 1;
        run_op(LW, 32'h500, 0, 1, 32'hCAFEF00D);
        check("post_rst_lw", last_rdata, 32'hCAFEF00D);

        // Random stream.
        for (int k = 0; k < 200; k++) begin
            logic [31:0] a;
            int lat;
            a = $urandom;
            if ($urandom % 2) a[1:0] = 2'b00;
            lat = ($urandom % 4 == 0) ? int'($urandom_range(10, 24)) : int'($urandom_range(0, 4));
            run_op(codes[$urandom % 9], a, $urandom, lat, $urandom);
            for (int g = 0; g < int'($urandom % 3); g++) begin
                mem_ack = 1'($urandom % 2); mem_rdata = $urandom;
                @(posedge clk); #1;
            end
            mem_ack = 0;
        end
        @(posedge clk); #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
